// File: rtl/disp_pkg.sv
// Shared display-scan constants: FSM encoding, digit count, select/anode idle patterns.
// Also holds the leading-zero lit-mask helper used when leading-zero blanking is built in.
package disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] SEL_IDLE   = 4'b0000;
    localparam logic [3:0] SEL_FIRST  = 4'b0001;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // Bit i set when digit i carries a significant nibble; digit 0 is always shown.
    function automatic logic [3:0] lit_mask(input logic [15:0] n);
        logic [3:0] m;
        m    = 4'b0001;
        m[1] = |n[15:4];
        m[2] = |n[15:8];
        m[3] = |n[15:12];
        return m;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A load of N-1 therefore yields a phase exactly N cycles long; clr forces zero.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/digit_scan_ctrl.sv
// 4-digit 7-segment scan controller: one-hot sel ring, active-low anodes with a blanking gap.
// Optional leading-zero anode blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module digit_scan_ctrl
    import disp_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] N,
    output logic [3:0]  sel,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SHOW_LD  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic       run_q;
    logic [1:0] state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] an_q, an_d;
    logic [1:0] idx_q, idx_d;
    logic       fd_q, fd_d;

    logic          tmr_clr, tmr_load, tc;
    logic [CW-1:0] tmr_ld_val;
    logic          adv;
    logic [3:0]    nsel;
    logic [1:0]    nidx;
    logic [3:0]    lit;

`ifdef LEADING_ZERO_BLANK_EN
    assign lit = lit_mask(N);
`else
    logic unused_n;
    assign lit      = 4'b1111;
    assign unused_n = ^N;
`endif

    phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .tc       (tc)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        an_d       = an_q;
        idx_d      = idx_q;
        fd_d       = 1'b0;
        tmr_clr    = 1'b0;
        tmr_load   = 1'b0;
        tmr_ld_val = SHOW_LD;
        adv        = 1'b0;
        nsel       = SEL_FIRST;
        nidx       = 2'd0;

        // run_q holds the FSM for one edge after reset release.
        if (run_q) begin
            if (!en) begin
                state_d = ST_IDLE;
                sel_d   = SEL_IDLE;
                an_d    = AN_OFF;
                idx_d   = 2'd0;
                tmr_clr = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: adv = 1'b1;
                    ST_BLANK: begin
                        if (tc) begin
                            state_d  = ST_SHOW;
                            an_d     = ~(sel_q & lit);
                            tmr_load = 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (tc) begin
                            adv  = 1'b1;
                            nsel = {sel_q[2:0], sel_q[3]};
                            nidx = idx_q + 2'd1;
                            fd_d = (idx_q == 2'(NUM_DIGITS - 1));
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        sel_d   = SEL_IDLE;
                        an_d    = AN_OFF;
                        idx_d   = 2'd0;
                        tmr_clr = 1'b1;
                    end
                endcase

                // Start of a new digit slot: blank first unless the gap is configured away.
                if (adv) begin
                    sel_d    = nsel;
                    idx_d    = nidx;
                    tmr_load = 1'b1;
                    if (BLANK_CYCLES == 0) begin
                        state_d = ST_SHOW;
                        an_d    = ~(nsel & lit);
                    end else begin
                        state_d    = ST_BLANK;
                        an_d       = AN_OFF;
                        tmr_ld_val = BLANK_LD;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            state_q <= ST_IDLE;
            sel_q   <= SEL_IDLE;
            an_q    <= AN_OFF;
            idx_q   <= 2'd0;
            fd_q    <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            idx_q   <= idx_d;
            fd_q    <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: main instance PRESCALE=4/BLANK=2 plus a BLANK_CYCLES=0 instance.
// Respects LEADING_ZERO_BLANK_EN when defined for the build.
module tb_digit_scan_ctrl;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    typedef struct {
        logic        en;
        logic [15:0] n;
        exp_t        e;
        exp_t        e0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] n;
    logic [3:0]  sel, an, sel0, an0;
    logic [1:0]  idx, idx0;
    logic        fd, fd0;

    int ntests = 0;
    int nfail  = 0;

    vec_t        tbl[72];
    logic [15:0] frame_n[3];
    logic [3:0]  frame_mask[3];
    exp_t        idle_e;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .N(n),
        .sel(sel), .an(an), .digit_idx(idx), .frame_done(fd)
    );

    digit_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .N(n),
        .sel(sel0), .an(an0), .digit_idx(idx0), .frame_done(fd0)
    );

    // Expected outputs t cycles after the IDLE->first-digit edge.
    function automatic exp_t model(int t, int blank, logic [3:0] mask);
        exp_t       r;
        int         per;
        int         d;
        int         p;
        logic [3:0] one;
        per   = 4 + blank;
        d     = (t / per) % 4;
        p     = t % per;
        one   = 4'b0001;
        r.sel = one << d;
        r.idx = 2'(d);
        r.an  = (p >= blank) ? ~(r.sel & mask) : 4'b1111;
        r.fd  = (t >= 4 * per) && (t % (4 * per) == 0);
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic chk_both(string tag, exp_t e, exp_t e0);
        chk({tag, " sel"},   16'(sel),  16'(e.sel));
        chk({tag, " an"},    16'(an),   16'(e.an));
        chk({tag, " idx"},   16'(idx),  16'(e.idx));
        chk({tag, " fd"},    16'(fd),   16'(e.fd));
        chk({tag, " sel0"},  16'(sel0), 16'(e0.sel));
        chk({tag, " an0"},   16'(an0),  16'(e0.an));
        chk({tag, " idx0"},  16'(idx0), 16'(e0.idx));
        chk({tag, " fd0"},   16'(fd0),  16'(e0.fd));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_e     = '{sel: 4'b0000, an: 4'b1111, idx: 2'd0, fd: 1'b0};
        frame_n    = '{16'h0042, 16'h0000, 16'h1000};
`ifdef LEADING_ZERO_BLANK_EN
        frame_mask = '{4'b0011, 4'b0001, 4'b1111};
`else
        frame_mask = '{4'b1111, 4'b1111, 4'b1111};
`endif
        for (int k = 0; k < 72; k++) begin
            tbl[k].en = 1'b1;
            tbl[k].n  = frame_n[k / 24];
            tbl[k].e  = model(k, 2, frame_mask[k / 24]);
            tbl[k].e0 = model(k, 0, frame_mask[k / 24]);
        end

        // Reset held with en=1: everything dark.
        rst_n = 1'b0;
        en    = 1'b1;
        n     = tbl[0].n;
        repeat (3) step();
        chk_both("reset", idle_e, idle_e);

        // Release: one edge to leave reset, then IDLE->BLANK, 2 BLANK, SHOW.
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_both("release", idle_e, idle_e);

        for (int k = 0; k < 72; k++) begin
            en = tbl[k].en;
            n  = tbl[k].n;
            step();
            chk_both($sformatf("run t=%0d", k), tbl[k].e, tbl[k].e0);
        end

        // Run on into mid-SHOW of digit 2 (t=87), then disable.
        for (int t = 72; t <= 87; t++) begin
            step();
            chk_both($sformatf("run t=%0d", t), model(t, 2, frame_mask[2]), model(t, 0, frame_mask[2]));
        end
        en = 1'b0;
        step();
        chk_both("disable", idle_e, idle_e);
        step();
        chk_both("disable hold", idle_e, idle_e);

        en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            chk_both($sformatf("reenable t=%0d", t), model(t, 2, frame_mask[2]), model(t, 0, frame_mask[2]));
        end

        // Async reset pulse between edges during SHOW: anodes dark before any clock.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async an", 16'(an), 16'h000f);
        chk("async sel", 16'(sel), 16'h0000);
        chk("async an0", 16'(an0), 16'h000f);
        #1;
        rst_n = 1'b1;
        step();
        chk_both("post reset", idle_e, idle_e);
        for (int t = 0; t < 4; t++) begin
            step();
            chk_both($sformatf("restart t=%0d", t), model(t, 2, frame_mask[2]), model(t, 0, frame_mask[2]));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
